// File: rtl/xpb_lut_loadable.sv
// Run-time loadable XPB lookup table: narrow beat stream fills DEPTH entries, registered lookup reads them.
// Optional macro XPB_LUT_OUTREG_EN adds a second output register stage (lookup latency 2 instead of 1).
module xpb_lut_loadable #(
  parameter int IDX_W  = 5,
  parameter int DATA_W = 1024,
  parameter int LOAD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [LOAD_W-1:0] ld_data,
  output logic              table_ready,
  input  logic              lk_valid,
  input  logic [IDX_W-1:0]  lk_idx,
  output logic              lk_out_valid,
  output logic [DATA_W-1:0] lk_out_data,
  output logic              lk_drop
);

  localparam int BEATS = DATA_W / LOAD_W;
  localparam int DEPTH = 2 ** IDX_W;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_e;

  state_e              state_q, state_d;
  logic [BCW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]    ent_cnt_q, ent_cnt_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic [DATA_W-1:0]   beat_ext;
  logic                wr_en;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      ent_cnt_q  <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      ent_cnt_q  <= ent_cnt_d;
      asm_q      <= asm_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    ent_cnt_d   = ent_cnt_q;
    asm_d       = asm_q;
    wr_en       = 1'b0;
    ld_ready    = 1'b0;
    table_ready = 1'b0;
    beat_ext    = DATA_W'(ld_data);
    case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d    = LOAD;
          beat_cnt_d = '0;
          ent_cnt_d  = '0;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_start) begin
          // Restart discards any beat presented in the same cycle.
          beat_cnt_d = '0;
          ent_cnt_d  = '0;
        end else if (ld_valid) begin
          // Beats enter at the top and shift down, so the first beat ends up in the LSBs.
          asm_d = (asm_q >> LOAD_W) | (beat_ext << (DATA_W - LOAD_W));
          if (beat_cnt_q == BCW'(BEATS - 1)) begin
            wr_en      = 1'b1;
            beat_cnt_d = '0;
            ent_cnt_d  = ent_cnt_q + IDX_W'(1);
            if (ent_cnt_q == IDX_W'(DEPTH - 1)) state_d = READY;
          end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end
        end
      end
      READY: begin
        table_ready = 1'b1;
        if (ld_start) begin
          state_d    = LOAD;
          beat_cnt_d = '0;
          ent_cnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage is deliberately not reset; it is only meaningful once table_ready is high.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[ent_cnt_q] <= asm_d;
  end

  logic              lk_acc;
  logic              s1_vld_q, s1_drop_q;
  logic [DATA_W-1:0] s1_dat_q;

  assign lk_acc = lk_valid & table_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_drop_q <= 1'b0;
      s1_dat_q  <= '0;
    end else begin
      s1_vld_q  <= lk_acc;
      s1_drop_q <= lk_valid & ~table_ready;
      if (lk_acc) s1_dat_q <= mem_q[lk_idx];
    end
  end

`ifdef XPB_LUT_OUTREG_EN
  logic              s2_vld_q, s2_drop_q;
  logic [DATA_W-1:0] s2_dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q  <= 1'b0;
      s2_drop_q <= 1'b0;
      s2_dat_q  <= '0;
    end else begin
      s2_vld_q  <= s1_vld_q;
      s2_drop_q <= s1_drop_q;
      if (s1_vld_q) s2_dat_q <= s1_dat_q;
    end
  end

  assign lk_out_valid = s2_vld_q;
  assign lk_drop      = s2_drop_q;
  assign lk_out_data  = s2_dat_q;
`else
  assign lk_out_valid = s1_vld_q;
  assign lk_drop      = s1_drop_q;
  assign lk_out_data  = s1_dat_q;
`endif

endmodule
